// File: rtl/bi_bus_arbiter.sv
// Two-requester round-robin arbiter feeding a bus-invert coded link.
// Grants one word per cycle, codes it against the current bus word, and tracks inversion statistics.
module bi_bus_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  input  logic         bus_stall,
  output logic [W-1:0] bus_data,
  output logic         bus_inv,
  output logic         bus_valid,
  output logic [15:0]  inv_cnt,
  output logic [15:0]  saved_cnt
);

  localparam int HW = $clog2(W + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        fsm, fsm_n;
  logic          rr_ptr, rr_ptr_n;
  logic [BW-1:0] burst, burst_n;
  logic [W-1:0]  bus_data_n;
  logic          bus_inv_n, bus_valid_n;
  logic [15:0]   inv_cnt_n, saved_cnt_n;

  logic          sel_valid, sel_id;
  logic [W-1:0]  sel_data, diff;
  logic [HW-1:0] hd;
  logic          invert, burst_full, same_owner;
  logic [16:0]   inv_sum, saved_inc, saved_sum;

  assign burst_full = (burst == BW'(MAX_BURST));

  // The current owner keeps the bus until its burst is spent, unless nobody else wants it.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    case (fsm)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          sel_valid = 1'b1;
          sel_id    = rr_ptr;
        end else if (req0_valid || req1_valid) begin
          sel_valid = 1'b1;
          sel_id    = req1_valid;
        end
      end
      OWN0: begin
        if (req0_valid && (!burst_full || !req1_valid)) begin
          sel_valid = 1'b1;
          sel_id    = 1'b0;
        end else if (req1_valid) begin
          sel_valid = 1'b1;
          sel_id    = 1'b1;
        end
      end
      OWN1: begin
        if (req1_valid && (!burst_full || !req0_valid)) begin
          sel_valid = 1'b1;
          sel_id    = 1'b1;
        end else if (req0_valid) begin
          sel_valid = 1'b1;
          sel_id    = 1'b0;
        end
      end
      default: begin
        sel_valid = 1'b0;
        sel_id    = 1'b0;
      end
    endcase
  end

  assign req0_ready = !rst && !bus_stall && sel_valid && !sel_id;
  assign req1_ready = !rst && !bus_stall && sel_valid && sel_id;

  // Hamming distance is taken against the coded word actually on the wires.
  always_comb begin
    sel_data = sel_id ? req1_data : req0_data;
    diff     = sel_data ^ bus_data;
    hd       = '0;
    for (int i = 0; i < W; i++) begin
      hd = hd + HW'(diff[i]);
    end
    invert    = (hd > HW'(W / 2));
    inv_sum   = {1'b0, inv_cnt} + 17'd1;
    saved_inc = (17'(hd) << 1) - 17'(W);
    saved_sum = {1'b0, saved_cnt} + saved_inc;
  end

  assign same_owner = ((fsm == OWN0) && !sel_id) || ((fsm == OWN1) && sel_id);

  always_comb begin
    fsm_n       = fsm;
    rr_ptr_n    = rr_ptr;
    burst_n     = burst;
    bus_data_n  = bus_data;
    bus_inv_n   = bus_inv;
    bus_valid_n = bus_valid;
    inv_cnt_n   = inv_cnt;
    saved_cnt_n = saved_cnt;
    if (!bus_stall) begin
      if (sel_valid) begin
        bus_valid_n = 1'b1;
        fsm_n       = sel_id ? OWN1 : OWN0;
        rr_ptr_n    = ~sel_id;
        burst_n     = (!same_owner || burst_full) ? BW'(1) : burst + BW'(1);
        bus_data_n  = invert ? ~sel_data : sel_data;
        bus_inv_n   = invert;
        if (invert) begin
          inv_cnt_n   = inv_sum[16]   ? 16'hFFFF : inv_sum[15:0];
          saved_cnt_n = saved_sum[16] ? 16'hFFFF : saved_sum[15:0];
        end
      end else begin
        // Idle: the bus keeps its last word so the data lines do not toggle.
        bus_valid_n = 1'b0;
        fsm_n       = IDLE;
        burst_n     = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      rr_ptr    <= 1'b0;
      burst     <= '0;
      bus_data  <= '0;
      bus_inv   <= 1'b0;
      bus_valid <= 1'b0;
      inv_cnt   <= '0;
      saved_cnt <= '0;
    end else begin
      fsm       <= fsm_n;
      rr_ptr    <= rr_ptr_n;
      burst     <= burst_n;
      bus_data  <= bus_data_n;
      bus_inv   <= bus_inv_n;
      bus_valid <= bus_valid_n;
      inv_cnt   <= inv_cnt_n;
      saved_cnt <= saved_cnt_n;
    end
  end

endmodule
